// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message sequencer: packs a byte stream into padded 512-bit chunks and feeds them to the core.
// Define SHA256_MSG_CTRL_WATCHDOG_EN to add a watchdog on the core finish wait (sticky err_o).
module sha256_msg_ctrl #(
    parameter int LEN_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic [31:0] s_data,
    input  logic [1:0]  s_bytes,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        hash_init_o,
    output logic        core_dat_valid_o,
    output logic [31:0] core_dat_o,
    input  logic        core_busy_i,
    input  logic        core_finish_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        LEN,
        WAIT
    } state_t;

    state_t            state, state_d;
    state_t            ret_state, ret_state_d;
    logic [4:0]        widx, widx_d;
    logic [LEN_W-1:0]  byte_cnt, byte_cnt_d;
    logic              marker_done, marker_done_d;
    logic              len_sent, len_sent_d;
    logic [31:0]       dat_p1, dat_d;
    logic              vld_p1, vld_d;
    logic              init_p1, init_d;
    logic              done_p1, done_d;
    logic [63:0]       bit_len;
    logic              accept;
    logic [2:0]        n_last;
    logic              unused_busy;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [2:0] last_bytes(input logic [1:0] b);
        return (b == 2'd0) ? 3'd4 : {1'b0, b};
    endfunction

    // Keep bytes 0..n-1, drop the 0x80 marker into byte n, clear the rest.
    function automatic logic [31:0] mark_last(input logic [31:0] w, input logic [2:0] n);
        logic [31:0] r;
        case (n)
            3'd1:    r = {16'h0000, 8'h80, w[7:0]};
            3'd2:    r = {8'h00, 8'h80, w[15:0]};
            3'd3:    r = {8'h80, w[23:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Where to go after emitting a padding-phase word at index idx.
    function automatic state_t pad_next(input logic [4:0] idx, input logic marked);
        state_t r;
        if (idx == 5'd15)
            r = WAIT;
        else if (marked && idx == 5'd13)
            r = LEN;
        else
            r = PAD;
        return r;
    endfunction

    assign bit_len     = 64'(byte_cnt) << 3;
    assign s_ready     = (state == DATA) && (widx < 5'd16);
    assign accept      = s_valid & s_ready;
    assign n_last      = last_bytes(s_bytes);
    assign busy_o      = (state != IDLE);
    assign unused_busy = core_busy_i;

`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_d;
    logic            err_q, err_d;
    assign err_o = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        ret_state_d   = ret_state;
        widx_d        = widx;
        byte_cnt_d    = byte_cnt;
        marker_done_d = marker_done;
        len_sent_d    = len_sent;
        dat_d         = dat_p1;
        vld_d         = 1'b0;
        init_d        = 1'b0;
        done_d        = 1'b0;
`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
        wd_cnt_d      = '0;
        err_d         = err_q;
`endif
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_d       = DATA;
                    init_d        = 1'b1;
                    widx_d        = 5'd0;
                    byte_cnt_d    = '0;
                    marker_done_d = 1'b0;
                    len_sent_d    = 1'b0;
                end
            end
            DATA: begin
                if (accept) begin
                    vld_d  = 1'b1;
                    widx_d = widx + 5'd1;
                    if (s_last) begin
                        byte_cnt_d    = byte_cnt + LEN_W'(n_last);
                        dat_d         = mark_last(s_data, n_last);
                        marker_done_d = (n_last != 3'd4);
                        state_d       = pad_next(widx, n_last != 3'd4);
                        ret_state_d   = PAD;
                    end else begin
                        byte_cnt_d  = byte_cnt + LEN_W'(4);
                        dat_d       = s_data;
                        state_d     = (widx == 5'd15) ? WAIT : DATA;
                        ret_state_d = DATA;
                    end
                end
            end
            PAD: begin
                vld_d         = 1'b1;
                widx_d        = widx + 5'd1;
                dat_d         = marker_done ? 32'h0000_0000 : 32'h0000_0080;
                marker_done_d = 1'b1;
                state_d       = pad_next(widx, 1'b1);
                ret_state_d   = PAD;
            end
            LEN: begin
                vld_d  = 1'b1;
                widx_d = widx + 5'd1;
                // Pre-swapped so the core's own byte swap yields a big-endian length.
                dat_d  = widx[0] ? bswap32(bit_len[31:0]) : bswap32(bit_len[63:32]);
                if (widx == 5'd15) begin
                    state_d    = WAIT;
                    len_sent_d = 1'b1;
                end
            end
            WAIT: begin
                if (core_finish_i) begin
                    widx_d = 5'd0;
                    if (len_sent) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ret_state;
                    end
                end
`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
                else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            state_d       = IDLE;
            ret_state_d   = IDLE;
            widx_d        = 5'd0;
            byte_cnt_d    = '0;
            marker_done_d = 1'b0;
            len_sent_d    = 1'b0;
            dat_d         = 32'h0000_0000;
            vld_d         = 1'b0;
            init_d        = 1'b0;
            done_d        = 1'b0;
`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
            wd_cnt_d      = '0;
            err_d         = 1'b0;
`endif
        end
    end

    // Stage p1: registered core-facing outputs and sequencer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            widx        <= 5'd0;
            byte_cnt    <= '0;
            marker_done <= 1'b0;
            len_sent    <= 1'b0;
            dat_p1      <= 32'h0000_0000;
            vld_p1      <= 1'b0;
            init_p1     <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
            state       <= state_d;
            ret_state   <= ret_state_d;
            widx        <= widx_d;
            byte_cnt    <= byte_cnt_d;
            marker_done <= marker_done_d;
            len_sent    <= len_sent_d;
            dat_p1      <= dat_d;
            vld_p1      <= vld_d;
            init_p1     <= init_d;
            done_p1     <= done_d;
        end
    end

`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_d;
            err_q  <= err_d;
        end
    end
`endif

    assign core_dat_o       = dat_p1;
    assign core_dat_valid_o = vld_p1;
    assign hash_init_o      = init_p1;
    assign done_o           = done_p1;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Directed bench for sha256_msg_ctrl: a small core model answers each chunk with a finish pulse.
`timescale 1ns/1ps
module tb_sha256_msg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic [31:0] s_data;
    logic [1:0]  s_bytes;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic        hash_init_o;
    logic        core_dat_valid_o;
    logic [31:0] core_dat_o;
    logic        core_busy_i;
    logic        core_finish_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    logic        model_fin = 1'b0;
    logic        tb_fin    = 1'b0;
    bit          auto_fin  = 1'b1;
    int          clear_req  = 0;
    int          clear_seen = 0;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_q[$];
    logic [7:0]  msg[$];
    int          chunk_words, done_cnt, init_cnt, fin_cnt, ready_bad, order_bad, wait_cyc;
    bit          in_wait;

    assign core_finish_i = model_fin | tb_fin;
    assign core_busy_i   = in_wait;

    always #5 clk = ~clk;

    sha256_msg_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr_i            (clr_i),
        .s_data           (s_data),
        .s_bytes          (s_bytes),
        .s_last           (s_last),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .hash_init_o      (hash_init_o),
        .core_dat_valid_o (core_dat_valid_o),
        .core_dat_o       (core_dat_o),
        .core_busy_i      (core_busy_i),
        .core_finish_i    (core_finish_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Core model: collects words, answers each full chunk with a finish pulse three cycles later.
    initial begin : core_model
        forever begin
            @(negedge clk);
            if (clear_seen != clear_req) begin
                got.delete();
                chunk_words = 0; done_cnt = 0; init_cnt = 0; fin_cnt = 0;
                ready_bad = 0; order_bad = 0; wait_cyc = 0; in_wait = 1'b0;
                model_fin = 1'b0;
                clear_seen = clear_req;
            end
            if (model_fin) model_fin = 1'b0;
            if (hash_init_o) init_cnt++;
            if (core_dat_valid_o) begin
                if (init_cnt == 0) order_bad++;
                got.push_back(core_dat_o);
                chunk_words++;
            end
            if (done_o) done_cnt++;
            if (chunk_words == 16 && !in_wait) begin
                in_wait  = 1'b1;
                wait_cyc = 0;
            end
            if (in_wait) begin
                if (s_ready) ready_bad++;
                if (auto_fin) begin
                    wait_cyc++;
                    if (wait_cyc == 3) begin
                        model_fin   = 1'b1;
                        in_wait     = 1'b0;
                        chunk_words = 0;
                        fin_cnt++;
                    end
                end
            end
        end
    end

    task automatic reset_model();
        clear_req++;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic fill_msg(input int n, input int base);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(base + i));
    endtask

    // Reference padding built byte-wise from the message, then packed byte0-low.
    task automatic build_exp();
        logic [7:0]  pad[$];
        logic [63:0] bits;
        pad  = msg;
        bits = 64'(msg.size()) << 3;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int w = 0; w < pad.size() / 4; w++)
            exp_q.push_back({pad[4*w+3], pad[4*w+2], pad[4*w+1], pad[4*w]});
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] b, input logic last);
        bit ok = 1'b0;
        s_data = d; s_bytes = b; s_last = last; s_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_bytes = 2'd0;
    endtask

    task automatic send_msg(input int max_gap);
        int nw;
        logic [31:0] d;
        nw = (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++)
                d[8*b +: 8] = (4*w + b < msg.size()) ? msg[4*w + b] : 8'hEE;
            send_word(d, (w == nw - 1) ? 2'(msg.size() % 4) : 2'd0, w == nw - 1);
            if (max_gap > 0)
                repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_msg(input string tag, input int max_gap);
        reset_model();
        build_exp();
        send_msg(max_gap);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_finishes"}, 64'(fin_cnt), 64'(exp_q.size() / 16));
        chk({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        chk({tag, "_ready_in_wait"}, 64'(ready_bad), 64'd0);
        chk({tag, "_hash_init"}, 64'(init_cnt), 64'd1);
        chk({tag, "_init_first"}, 64'(order_bad), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog_timer
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        rst_n = 1'b0; clr_i = 1'b0; s_data = '0; s_bytes = '0; s_last = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_hash_init", 64'(hash_init_o), 64'd0);
        chk("rst_valid", 64'(core_dat_valid_o), 64'd0);
        chk("rst_data", 64'(core_dat_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc"
        msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg("abc", 0);
        chk("abc_hand_w0", 64'(got[0]), 64'h8063_6261);
        chk("abc_hand_w14", 64'(got[14]), 64'h0);
        chk("abc_hand_w15", 64'(got[15]), 64'h1800_0000);

        // 56 bytes: marker spills, length goes into a second chunk
        fill_msg(56, 0);
        run_msg("m56", 0);
        chk("m56_hand_w14", 64'(got[14]), 64'h0000_0080);
        chk("m56_hand_w15", 64'(got[15]), 64'h0);
        chk("m56_hand_w31", 64'(got[31]), 64'hC001_0000);
        chk("m56_hand_fin", 64'(fin_cnt), 64'd2);

        // 52 bytes: marker at index 13, single chunk
        fill_msg(52, 16);
        run_msg("m52", 0);
        chk("m52_hand_w13", 64'(got[13]), 64'h0000_0080);
        chk("m52_hand_w15", 64'(got[15]), 64'hA001_0000);
        chk("m52_hand_fin", 64'(fin_cnt), 64'd1);

        // 70 bytes, gapless then with random s_valid gaps
        fill_msg(70, 0);
        run_msg("m70", 0);
        chk("m70_hand_w17", 64'(got[17]), 64'h0080_4544);
        chk("m70_hand_w31", 64'(got[31]), 64'h3002_0000);
        ref_q = got;
        run_msg("m70gap", 3);
        chk("gap_len", 64'(got.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++)
            chk($sformatf("gap_vs_gapless_w%0d", i), 64'(got[i]), 64'(ref_q[i]));

        // clr_i mid-chunk
        reset_model();
        fill_msg(40, 0);
        for (int w = 0; w < 5; w++) send_word({msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]}, 2'd0, 1'b0);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        chk("clr_mid_busy", 64'(busy_o), 64'd0);
        chk("clr_mid_valid", 64'(core_dat_valid_o), 64'd0);
        chk("clr_mid_data", 64'(core_dat_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("clr_mid_no_done", 64'(done_cnt), 64'd0);
        chk("clr_mid_s_ready", 64'(s_ready), 64'd0);

        // clr_i coincident with core_finish_i
        auto_fin = 1'b0;
        reset_model();
        for (int w = 0; w < 16; w++) send_word(32'h1111_0000 + 32'(w), 2'd0, 1'b0);
        clr_i = 1'b1; tb_fin = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0; tb_fin = 1'b0;
        chk("clr_fin_busy", 64'(busy_o), 64'd0);
        chk("clr_fin_done", 64'(done_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("clr_fin_no_done", 64'(done_cnt), 64'd0);
        chk("clr_fin_no_valid", 64'(core_dat_valid_o), 64'd0);
        auto_fin = 1'b1;

        msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg("abc_after_clr", 0);

        // Core finish withheld
        auto_fin = 1'b0;
        reset_model();
        for (int w = 0; w < 16; w++) send_word(32'h2222_0000 + 32'(w), 2'd0, 1'b0);
`ifdef SHA256_MSG_CTRL_WATCHDOG_EN
        begin
            int n_wait = 0;
            for (int k = 1; k <= 400; k++) begin
                @(posedge clk); #1;
                if (err_o) begin n_wait = k; break; end
            end
            chk("wd_wait_cycles", 64'(n_wait), 64'd255);
            chk("wd_err", 64'(err_o), 64'd1);
            chk("wd_idle", 64'(busy_o), 64'd0);
            chk("wd_no_done", 64'(done_cnt), 64'd0);
        end
`else
        repeat (300) @(posedge clk);
        #1;
        chk("nowd_err", 64'(err_o), 64'd0);
        chk("nowd_still_waiting", 64'(busy_o), 64'd1);
        chk("nowd_ready", 64'(s_ready), 64'd0);
`endif
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        chk("err_cleared", 64'(err_o), 64'd0);
        chk("err_clr_busy", 64'(busy_o), 64'd0);
        auto_fin = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
